cpu_datapath: RTL and testbench
===============================

Name: cpu_datapath

Overview:
- Single-bus 32-bit CPU datapath (SRC style): 16 GPRs, PC, IR, HI, LO, Y, 64-bit Z, MAR, MDR, in/out ports, ALU, condition flip-flop and a 512x32 RAM.
- An external control unit or bench drives one-hot bus-source and register-load strobes each cycle.
- All register state is exported for observation.

Parameters:
- MEM_DEPTH, 512, RAM words; MAR is log2 = 9 bits wide.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-low reset.
- HIin, Loin, PCin, IRin, Yin, MDRin, MARin, OPin, Rin  in  1 each  register load enables, loaded from the bus.
- Zin, ZHIin, ZLOin, ZHighSelect, ZLowSelect  in  1 each  Z load controls.
- HIout, Loout, PCout, MDRout, MARout, Yout, IRout, Cout, ZHIout, ZLOout, InPortout, Rout, BAout, CON_FF_Out  in  1 each  bus source selects.
- MDRread  in  1  MDR input mux: 1 = RAM read data, 0 = bus.
- IncPC  in  1  forces ALU result = bus + 1.
- Gra, Grb, Grc  in  1 each  select IR ra, rb or rc field as the register index.
- CON_FF_In  in  1  latch branch condition.
- wren  in  1  RAM write enable.
- ALUSelection  in  5  ALU opcode.
- in_32  in  32  input-port data.
- R0..R12, R15  out  32 each  GPR contents.
- R13, R14  out  16 each  low 16 bits of R13, R14 (registers are internally 32-bit).
- HI, LO, Y, IR, INPORT, OUTPORT  out  32 each.
- ZLO, ZHI  out  32 each  Z[31:0], Z[63:32].
- MAR  out  9.
- Z_register  out  64.

Behaviour:
- Reset: at a rising edge with clr=0, every register (GPRs, PC, IR, HI, LO, Y, Z, MAR, MDR, INPORT, OUTPORT, CON) clears to 0. RAM contents are not reset; RAM initial contents are 0. Reset overrides all loads.
- Bus is combinational. Exactly one source is expected.
  - Source priority if several are asserted: Rout/BAout > PCout > IRout > MDRout > HIout > Loout > Yout > ZHIout > ZLOout > InPortout > Cout > MARout > CON_FF_Out.
  - No source asserted: bus = 0.
- Bus source values:
  - Cout drives sign-extend(IR[18:0]).
  - MARout drives {23'b0, MAR}.
  - CON_FF_Out drives {31'b0, CON}.
- Select/encode: index = IR[26:23] if Gra, else IR[22:19] if Grb, else IR[18:15] if Grc, else 0.
  - Rin loads GPR[index] from the bus.
  - Rout drives GPR[index].
  - BAout drives GPR[index], except index 0 reads as 0.
- All loads occur on the rising clock edge with 1-cycle latency; the new value is visible on the bus the next cycle.
- INPORT samples in_32 every clock edge.
- MAR loads bus[8:0]. MDR loads from the RAM or the bus according to MDRread.
- RAM: read is asynchronous, mem[MAR]. Write: wren=1 writes MDR to mem[MAR] at the clock edge.
- ALU: A = Y, B = bus; 64-bit result; IncPC overrides to {32'b0, B+1}.
  - 00000 pass B
  - 00001 A+B
  - 00010 A-B
  - 00011 AND
  - 00100 OR
  - 00101 B+1
  - 00110 A>>B[4:0] logical
  - 00111 A<<B[4:0]
  - 01000 -B
  - 01001 ~B
  - 01010 signed A*B (64-bit)
  - All other codes give 0.
  - 32-bit results are zero-extended into bits 63:32.
- Z update:
  - Zin loads all 64 bits from the ALU.
  - Otherwise, ZLOin loads Z[31:0] from ALU[31:0] if ZLowSelect, else from the bus.
  - ZHIin loads Z[63:32] from ALU[63:32] if ZHighSelect, else from the bus.
  - Zin has priority over ZLOin/ZHIin.
- CON_FF_In sets CON from IR[20:19] against the bus:
  - 00: bus == 0
  - 01: bus != 0
  - 10: bus[31] == 0
  - 11: bus[31] == 1
- IR fields: op[31:27], ra[26:23], rb[22:19], rc[18:15], C[18:0].

Test Plan:
- Reset: clr=0 for one edge, then clr=1 -> all register outputs 0, Z_register = 0.
- addi R2,R4,68:
  - Stimulus: in_32=0x61200044; InPortout+IRin; then Cout+Yin; then Grb+Rout, ALUSelection=00001, Zin; then Gra+Rin+ZLOout.
  - Expected: IR=0x61200044, Y=0x44, R2=0x44 (R4=0).
- IncPC: InPortout with in_32=0x10, IncPC+Zin+MARin; then ZLOout+PCin -> MAR=0x010, ZLO=0x11, PC=0x11.
- Memory round trip: bus value 0x0000ABCD into MDR, MAR=5, wren -> mem[5]=0x0000ABCD; a later MDRread+MDRin reloads MDR=0x0000ABCD.
- Multiply: Y=0xFFFFFFFE, B=3, op 01010, Zin -> Z_register = 0xFFFFFFFFFFFFFFFA.
- CON FF: IR[20:19]=01 with bus=0 -> CON=0; with bus=7 -> CON=1. BAout with rb=0 and R0=5 drives bus=0.

Source files
------------

// File: rtl/cpu_datapath.sv
// rtl/cpu_datapath.sv - single-bus 32-bit CPU datapath with GPRs, ALU, Z, CON FF and RAM
module cpu_datapath #(
    parameter int MEM_DEPTH = 512
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        HIin,
    input  logic        Loin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        Yin,
    input  logic        MDRin,
    input  logic        MARin,
    input  logic        OPin,
    input  logic        Rin,
    input  logic        Zin,
    input  logic        ZHIin,
    input  logic        ZLOin,
    input  logic        ZHighSelect,
    input  logic        ZLowSelect,
    input  logic        HIout,
    input  logic        Loout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        MARout,
    input  logic        Yout,
    input  logic        IRout,
    input  logic        Cout,
    input  logic        ZHIout,
    input  logic        ZLOout,
    input  logic        InPortout,
    input  logic        Rout,
    input  logic        BAout,
    input  logic        CON_FF_Out,
    input  logic        MDRread,
    input  logic        IncPC,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        CON_FF_In,
    input  logic        wren,
    input  logic [4:0]  ALUSelection,
    input  logic [31:0] in_32,
    output logic [31:0] R0,
    output logic [31:0] R1,
    output logic [31:0] R2,
    output logic [31:0] R3,
    output logic [31:0] R4,
    output logic [31:0] R5,
    output logic [31:0] R6,
    output logic [31:0] R7,
    output logic [31:0] R8,
    output logic [31:0] R9,
    output logic [31:0] R10,
    output logic [31:0] R11,
    output logic [31:0] R12,
    output logic [15:0] R13,
    output logic [15:0] R14,
    output logic [31:0] R15,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Y,
    output logic [31:0] IR,
    output logic [31:0] INPORT,
    output logic [31:0] OUTPORT,
    output logic [31:0] ZLO,
    output logic [31:0] ZHI,
    output logic [$clog2(MEM_DEPTH)-1:0] MAR,
    output logic [63:0] Z_register
);

    localparam int AW = $clog2(MEM_DEPTH);

    logic [31:0] gpr_q [16];
    logic [31:0] gpr_d [16];
    logic [31:0] pc_q, pc_d, ir_q, ir_d, hi_q, hi_d, lo_q, lo_d, y_q, y_d;
    logic [31:0] mdr_q, mdr_d, inport_q, inport_d, outport_q, outport_d;
    logic [63:0] z_q, z_d;
    logic [AW-1:0] mar_q, mar_d;
    logic        con_q, con_d;

    logic [31:0] mem [MEM_DEPTH];
    logic [31:0] mem_rdata;
    logic [31:0] bus;
    logic [63:0] alu;
    logic [3:0]  idx;
    logic signed [63:0] prod;
    logic        cond;
    logic        opcode_unused;

    assign opcode_unused = ^ir_q[31:27];
    assign mem_rdata     = mem[mar_q];

    always_comb begin
        idx = 4'd0;
        if (Gra)      idx = ir_q[26:23];
        else if (Grb) idx = ir_q[22:19];
        else if (Grc) idx = ir_q[18:15];
    end

    // Several sources at once is a control-unit bug; the chain just makes it deterministic.
    always_comb begin
        bus = 32'd0;
        if (Rout)            bus = gpr_q[idx];
        else if (BAout)      bus = (idx == 4'd0) ? 32'd0 : gpr_q[idx];
        else if (PCout)      bus = pc_q;
        else if (IRout)      bus = ir_q;
        else if (MDRout)     bus = mdr_q;
        else if (HIout)      bus = hi_q;
        else if (Loout)      bus = lo_q;
        else if (Yout)       bus = y_q;
        else if (ZHIout)     bus = z_q[63:32];
        else if (ZLOout)     bus = z_q[31:0];
        else if (InPortout)  bus = inport_q;
        else if (Cout)       bus = {{13{ir_q[18]}}, ir_q[18:0]};
        else if (MARout)     bus = {{(32-AW){1'b0}}, mar_q};
        else if (CON_FF_Out) bus = {31'd0, con_q};
    end

    assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});

    always_comb begin
        alu = 64'd0;
        if (IncPC) begin
            alu = {32'd0, bus + 32'd1};
        end else begin
            case (ALUSelection)
                5'b00000: alu = {32'd0, bus};
                5'b00001: alu = {32'd0, y_q + bus};
                5'b00010: alu = {32'd0, y_q - bus};
                5'b00011: alu = {32'd0, y_q & bus};
                5'b00100: alu = {32'd0, y_q | bus};
                5'b00101: alu = {32'd0, bus + 32'd1};
                5'b00110: alu = {32'd0, y_q >> bus[4:0]};
                5'b00111: alu = {32'd0, y_q << bus[4:0]};
                5'b01000: alu = {32'd0, -bus};
                5'b01001: alu = {32'd0, ~bus};
                5'b01010: alu = prod;
                default:  alu = 64'd0;
            endcase
        end
    end

    always_comb begin
        cond = 1'b0;
        case (ir_q[20:19])
            2'b00: cond = (bus == 32'd0);
            2'b01: cond = (bus != 32'd0);
            2'b10: cond = ~bus[31];
            2'b11: cond = bus[31];
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        gpr_d = gpr_q;
        if (Rin) gpr_d[idx] = bus;
        pc_d      = PCin  ? bus : pc_q;
        ir_d      = IRin  ? bus : ir_q;
        hi_d      = HIin  ? bus : hi_q;
        lo_d      = Loin  ? bus : lo_q;
        y_d       = Yin   ? bus : y_q;
        outport_d = OPin  ? bus : outport_q;
        mar_d     = MARin ? bus[AW-1:0] : mar_q;
        mdr_d     = MDRin ? (MDRread ? mem_rdata : bus) : mdr_q;
        inport_d  = in_32;
        con_d     = CON_FF_In ? cond : con_q;
        z_d       = z_q;
        if (Zin) begin
            z_d = alu;
        end else begin
            if (ZLOin) z_d[31:0]  = ZLowSelect  ? alu[31:0]  : bus;
            if (ZHIin) z_d[63:32] = ZHighSelect ? alu[63:32] : bus;
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= 32'd0;
            pc_q      <= 32'd0;
            ir_q      <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            y_q       <= 32'd0;
            mdr_q     <= 32'd0;
            inport_q  <= 32'd0;
            outport_q <= 32'd0;
            z_q       <= 64'd0;
            mar_q     <= '0;
            con_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            y_q       <= y_d;
            mdr_q     <= mdr_d;
            inport_q  <= inport_d;
            outport_q <= outport_d;
            z_q       <= z_d;
            mar_q     <= mar_d;
            con_q     <= con_d;
        end
    end

    // RAM contents survive reset; only the register file is cleared.
    always_ff @(posedge clk) begin
        if (wren) mem[mar_q] <= mdr_q;
    end

    assign R0  = gpr_q[0];
    assign R1  = gpr_q[1];
    assign R2  = gpr_q[2];
    assign R3  = gpr_q[3];
    assign R4  = gpr_q[4];
    assign R5  = gpr_q[5];
    assign R6  = gpr_q[6];
    assign R7  = gpr_q[7];
    assign R8  = gpr_q[8];
    assign R9  = gpr_q[9];
    assign R10 = gpr_q[10];
    assign R11 = gpr_q[11];
    assign R12 = gpr_q[12];
    assign R13 = gpr_q[13][15:0];
    assign R14 = gpr_q[14][15:0];
    assign R15 = gpr_q[15];
    assign HI         = hi_q;
    assign LO         = lo_q;
    assign Y          = y_q;
    assign IR         = ir_q;
    assign INPORT     = inport_q;
    assign OUTPORT    = outport_q;
    assign ZLO        = z_q[31:0];
    assign ZHI        = z_q[63:32];
    assign MAR        = mar_q;
    assign Z_register = z_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// tb/tb_cpu_datapath.sv - table-driven directed bench for cpu_datapath
module tb_cpu_datapath;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr;
    logic HIin, Loin, PCin, IRin, Yin, MDRin, MARin, OPin, Rin;
    logic Zin, ZHIin, ZLOin, ZHighSelect, ZLowSelect;
    logic HIout, Loout, PCout, MDRout, MARout, Yout, IRout, Cout, ZHIout, ZLOout;
    logic InPortout, Rout, BAout, CON_FF_Out, MDRread, IncPC, Gra, Grb, Grc, CON_FF_In, wren;
    logic [4:0]  ALUSelection;
    logic [31:0] in_32;
    logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R15;
    logic [15:0] R13, R14;
    logic [31:0] HI, LO, Y, IR, INPORT, OUTPORT, ZLO, ZHI;
    logic [8:0]  MAR;
    logic [63:0] Z_register;

    cpu_datapath #(.MEM_DEPTH(512)) dut (
        .clk(clk), .clr(clr),
        .HIin(HIin), .Loin(Loin), .PCin(PCin), .IRin(IRin), .Yin(Yin), .MDRin(MDRin),
        .MARin(MARin), .OPin(OPin), .Rin(Rin),
        .Zin(Zin), .ZHIin(ZHIin), .ZLOin(ZLOin), .ZHighSelect(ZHighSelect), .ZLowSelect(ZLowSelect),
        .HIout(HIout), .Loout(Loout), .PCout(PCout), .MDRout(MDRout), .MARout(MARout),
        .Yout(Yout), .IRout(IRout), .Cout(Cout), .ZHIout(ZHIout), .ZLOout(ZLOout),
        .InPortout(InPortout), .Rout(Rout), .BAout(BAout), .CON_FF_Out(CON_FF_Out),
        .MDRread(MDRread), .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .CON_FF_In(CON_FF_In), .wren(wren), .ALUSelection(ALUSelection), .in_32(in_32),
        .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
        .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14), .R15(R15),
        .HI(HI), .LO(LO), .Y(Y), .IR(IR), .INPORT(INPORT), .OUTPORT(OUTPORT),
        .ZLO(ZLO), .ZHI(ZHI), .MAR(MAR), .Z_register(Z_register)
    );

    localparam logic [63:0] HIIN = 64'd1 << 0,  LOIN = 64'd1 << 1,  PCIN = 64'd1 << 2;
    localparam logic [63:0] IRIN = 64'd1 << 3,  YIN = 64'd1 << 4,   MDRIN = 64'd1 << 5;
    localparam logic [63:0] MARIN = 64'd1 << 6, OPIN = 64'd1 << 7,  RIN = 64'd1 << 8;
    localparam logic [63:0] ZIN = 64'd1 << 9,   ZHIIN = 64'd1 << 10, ZLOIN = 64'd1 << 11;
    localparam logic [63:0] ZHS = 64'd1 << 12,  ZLS = 64'd1 << 13,  HIOUT = 64'd1 << 14;
    localparam logic [63:0] LOOUT = 64'd1 << 15, PCOUT = 64'd1 << 16, MDROUT = 64'd1 << 17;
    localparam logic [63:0] MAROUT = 64'd1 << 18, YOUT = 64'd1 << 19, IROUT = 64'd1 << 20;
    localparam logic [63:0] COUT = 64'd1 << 21, ZHIOUT = 64'd1 << 22, ZLOOUT = 64'd1 << 23;
    localparam logic [63:0] INOUT = 64'd1 << 24, ROUT = 64'd1 << 25, BAOUT = 64'd1 << 26;
    localparam logic [63:0] CONOUT = 64'd1 << 27, MDRRD = 64'd1 << 28, INCPC = 64'd1 << 29;
    localparam logic [63:0] GRA = 64'd1 << 30, GRB = 64'd1 << 31, GRC = 64'd1 << 32;
    localparam logic [63:0] CONIN = 64'd1 << 33, WREN = 64'd1 << 34;

    typedef enum int {K_NONE, K_IR, K_Y, K_R0, K_R2, K_MAR, K_Z, K_HI, K_LO, K_OUT, K_IN} chk_e;

    typedef struct {
        logic [63:0] ctl;
        logic [4:0]  alu;
        logic [31:0] din;
        chk_e        chk;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic drive(input logic [63:0] c, input logic [4:0] a, input logic [31:0] d);
        {HIin, Loin, PCin, IRin, Yin, MDRin, MARin, OPin, Rin} =
            {c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], c[8]};
        {Zin, ZHIin, ZLOin, ZHighSelect, ZLowSelect} = {c[9], c[10], c[11], c[12], c[13]};
        {HIout, Loout, PCout, MDRout, MARout, Yout, IRout} =
            {c[14], c[15], c[16], c[17], c[18], c[19], c[20]};
        {Cout, ZHIout, ZLOout, InPortout, Rout, BAout, CON_FF_Out} =
            {c[21], c[22], c[23], c[24], c[25], c[26], c[27]};
        {MDRread, IncPC, Gra, Grb, Grc, CON_FF_In, wren} =
            {c[28], c[29], c[30], c[31], c[32], c[33], c[34]};
        ALUSelection = a;
        in_32        = d;
    endtask

    function automatic logic [63:0] obs(input chk_e k);
        case (k)
            K_IR:    return {32'd0, IR};
            K_Y:     return {32'd0, Y};
            K_R0:    return {32'd0, R0};
            K_R2:    return {32'd0, R2};
            K_MAR:   return {55'd0, MAR};
            K_Z:     return Z_register;
            K_HI:    return {32'd0, HI};
            K_LO:    return {32'd0, LO};
            K_OUT:   return {32'd0, OUTPORT};
            K_IN:    return {32'd0, INPORT};
            default: return 64'd0;
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [63:0] c, input logic [4:0] a, input logic [31:0] d,
                       input chk_e k, input logic [63:0] e);
        vec_t v;
        v = '{ctl: c, alu: a, din: d, chk: k, exp: e};
        vecs.push_back(v);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ir"},  {32'd0, IR}, 64'd0);
        check({tag, "_y"},   {32'd0, Y}, 64'd0);
        check({tag, "_z"},   Z_register, 64'd0);
        check({tag, "_in"},  {32'd0, INPORT}, 64'd0);
        check({tag, "_mar"}, {55'd0, MAR}, 64'd0);
        check({tag, "_hilo"}, {HI, LO}, 64'd0);
        check({tag, "_out"}, {32'd0, OUTPORT}, 64'd0);
        check({tag, "_r0r2"}, {R0, R2}, 64'd0);
        check({tag, "_r15"}, {16'd0, R13, R14, R15}, 64'd0);
    endtask

    initial begin
        // addi R2,R4,68
        add(64'd0,                 5'h00, 32'h61200044, K_IN,  64'h61200044);
        add(INOUT | IRIN,          5'h00, 32'h0,        K_IR,  64'h61200044);
        add(COUT | YIN,            5'h00, 32'h0,        K_Y,   64'h44);
        add(GRB | ROUT | ZIN,      5'h01, 32'h0,        K_Z,   64'h44);
        add(GRA | RIN | ZLOOUT,    5'h00, 32'h10,       K_R2,  64'h44);
        // IncPC
        add(INOUT | INCPC | ZIN | MARIN, 5'h07, 32'h0,  K_MAR, 64'h10);
        add(ZLOOUT | PCIN,         5'h00, 32'h0,        K_Z,   64'h11);
        add(PCOUT | YIN,           5'h00, 32'h0000ABCD, K_Y,   64'h11);
        // Memory round trip
        add(INOUT | MDRIN | YIN,   5'h00, 32'h5,        K_Y,   64'hABCD);
        add(INOUT | MARIN,         5'h00, 32'h0,        K_MAR, 64'h5);
        add(WREN,                  5'h00, 32'h0,        K_NONE, 64'h0);
        add(INOUT | MDRIN,         5'h00, 32'h0,        K_NONE, 64'h0);
        add(MDROUT | YIN,          5'h00, 32'h0,        K_Y,   64'h0);
        add(MDRRD | MDRIN,         5'h00, 32'h0,        K_NONE, 64'h0);
        add(MDROUT | YIN,          5'h00, 32'hFFFFFFFE, K_Y,   64'hABCD);
        // ALU sweep with Y=0xFFFFFFFE, B=3
        add(INOUT | YIN,           5'h00, 32'h3,        K_Y,   64'hFFFFFFFE);
        add(INOUT | ZIN,           5'h0A, 32'h3,        K_Z,   64'hFFFFFFFF_FFFFFFFA);
        add(INOUT | ZIN,           5'h00, 32'h3,        K_Z,   64'h3);
        add(INOUT | ZIN,           5'h01, 32'h3,        K_Z,   64'h1);
        add(INOUT | ZIN,           5'h02, 32'h3,        K_Z,   64'hFFFFFFFB);
        add(INOUT | ZIN,           5'h03, 32'h3,        K_Z,   64'h2);
        add(INOUT | ZIN,           5'h04, 32'h3,        K_Z,   64'hFFFFFFFF);
        add(INOUT | ZIN,           5'h05, 32'h3,        K_Z,   64'h4);
        add(INOUT | ZIN,           5'h06, 32'h3,        K_Z,   64'h1FFFFFFF);
        add(INOUT | ZIN,           5'h07, 32'h3,        K_Z,   64'hFFFFFFF0);
        add(INOUT | ZIN,           5'h08, 32'h3,        K_Z,   64'hFFFFFFFD);
        add(INOUT | ZIN,           5'h1F, 32'h3,        K_Z,   64'h0);
        add(INOUT | ZIN,           5'h09, 32'h3,        K_Z,   64'hFFFFFFFC);
        add(INOUT | ZIN,           5'h0B, 32'h3,        K_Z,   64'h0);
        // Split Z loads, HI/LO/OUTPORT
        add(INOUT | ZHIIN,         5'h00, 32'h3,        K_Z,   64'h00000003_00000000);
        add(INOUT | ZLOIN | ZLS,   5'h01, 32'h3,        K_Z,   64'h00000003_00000001);
        add(ZHIOUT | HIIN,         5'h00, 32'h3,        K_HI,  64'h3);
        add(ZLOOUT | LOIN,         5'h00, 32'h3,        K_LO,  64'h1);
        add(HIOUT | OPIN,          5'h00, 32'h3,        K_OUT, 64'h3);
        add(INOUT | ZHIIN | ZHS,   5'h0A, 32'h3,        K_Z,   64'hFFFFFFFF_00000001);
        add(INOUT | ZIN | ZLOIN | ZHIIN, 5'h00, 32'h00080000, K_Z, 64'h3);
        // CON FF with IR[20:19]=01
        add(INOUT | IRIN,          5'h00, 32'h7,        K_IR,  64'h00080000);
        add(INOUT | CONIN,         5'h00, 32'h0,        K_NONE, 64'h0);
        add(CONOUT | YIN,          5'h00, 32'h0,        K_Y,   64'h1);
        add(CONIN,                 5'h00, 32'h0,        K_NONE, 64'h0);
        add(CONOUT | YIN,          5'h00, 32'h00040000, K_Y,   64'h0);
        // Cout sign extension, MARout
        add(INOUT | IRIN,          5'h00, 32'h0,        K_IR,  64'h00040000);
        add(COUT | YIN,            5'h00, 32'h0,        K_Y,   64'hFFFC0000);
        add(MAROUT | YIN,          5'h00, 32'h0,        K_Y,   64'h5);
        // BAout with rb=0, bus priority
        add(IRIN,                  5'h00, 32'h5,        K_IR,  64'h0);
        add(INOUT | RIN,           5'h00, 32'h0,        K_R0,  64'h5);
        add(BAOUT | GRB | YIN,     5'h00, 32'h0,        K_Y,   64'h0);
        add(ROUT | GRB | PCOUT | YIN,  5'h00, 32'h0,    K_Y,   64'h5);
        add(BAOUT | GRB | PCOUT | YIN, 5'h00, 32'h0,    K_Y,   64'h0);

        clr = 1'b0;
        drive(INOUT | YIN | IRIN | ZIN, 5'h05, 32'hDEADBEEF);
        @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        clr = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ctl, vecs[i].alu, vecs[i].din);
            @(posedge clk);
            @(negedge clk);
            if (vecs[i].chk != K_NONE)
                check($sformatf("vec%0d_chk%0d", i, vecs[i].chk), obs(vecs[i].chk), vecs[i].exp);
        end

        // Reset asserted mid-run while loads are active must win.
        clr = 1'b0;
        drive(INOUT | YIN | RIN | IRIN | ZIN | MARIN | OPIN, 5'h05, 32'h12345678);
        @(posedge clk);
        @(negedge clk);
        check_reset("midreset");
        clr = 1'b1;
        drive(64'd0, 5'h00, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("post_reset_in", {32'd0, INPORT}, 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
